// File: rtl/me_sad_search.sv
// Full-search SAD block matcher: streams LANES pixel pairs per beat, scores every
// candidate of the (2*RANGE+1)^2 window and keeps the first strict minimum. Macro ME_CAND_SAD_EN adds cand_valid/cand_sad.
module me_sad_search #(
   parameter int WORD_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int BLOCK_N    = 16,
   parameter int RANGE      = 7,
   localparam int DATA_W    = LANES * WORD_WIDTH,
   localparam int SAD_W     = WORD_WIDTH + $clog2(BLOCK_N * BLOCK_N),
   localparam int MV_W      = $clog2(RANGE + 1) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   init,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      cur_data,
   input  logic [DATA_W-1:0]      ref_data,
   output logic                   busy,
   output logic                   done,
   output logic [SAD_W-1:0]       min_sad,
   output logic signed [MV_W-1:0] mv_x,
   output logic signed [MV_W-1:0] mv_y
`ifdef ME_CAND_SAD_EN
   ,
   output logic                   cand_valid,
   output logic [SAD_W-1:0]       cand_sad
`endif
);

   localparam int BEATS  = BLOCK_N * BLOCK_N / LANES;
   localparam int BEAT_W = $clog2(BEATS + 1);
   localparam int SPAN   = 2 * RANGE + 1;
   localparam int POS_W  = $clog2(SPAN + 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
   localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SPAN - 1);
   localparam logic [MV_W-1:0]   RANGE_V   = MV_W'(RANGE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                  state_r, state_s;
   logic                    accept_s;
   logic                    beat_last_s;
   logic                    cand_last_s;
   logic [BEAT_W-1:0]       beat_cnt_r;
   logic [POS_W-1:0]        in_x_r, in_y_r;
   logic [WORD_WIDTH-1:0]   s1_diff_r [LANES];
   logic                    s1_vld_r, s1_first_r, s1_last_r;
   logic [SAD_W-1:0]        lane_sum_s;
   logic [SAD_W-1:0]        acc_r;
   logic                    acc_done_r;
   logic [POS_W-1:0]        cmp_x_r, cmp_y_r;
   logic                    cmp_last_r;
   logic                    cmp_first_s;

   function automatic logic [WORD_WIDTH-1:0] abs_diff(input logic [WORD_WIDTH-1:0] a,
                                                      input logic [WORD_WIDTH-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // A beat presented together with init belongs to the aborted search and is dropped.
   assign accept_s    = in_valid & in_ready & ~init;
   assign beat_last_s = (beat_cnt_r == BEAT_LAST);
   assign cand_last_s = (in_x_r == POS_LAST) && (in_y_r == POS_LAST);
   assign cmp_first_s = (cmp_x_r == '0) && (cmp_y_r == '0);

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (init) state_s = ST_RUN;
            else      state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (init)                                       state_s = ST_RUN;
            else if (accept_s && beat_last_s && cand_last_s) state_s = ST_FLUSH;
            else                                            state_s = ST_RUN;
         end
         ST_FLUSH: begin
            if (init)            state_s = ST_RUN;
            else if (cmp_last_r) state_s = ST_DONE;
            else                 state_s = ST_FLUSH;
         end
         ST_DONE: begin
            if (init) state_s = ST_RUN;
            else      state_s = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register; handshake and status outputs are registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_r  <= state_s;
         in_ready <= (state_s == ST_RUN);
         busy     <= (state_s == ST_RUN) || (state_s == ST_FLUSH);
         done     <= (state_s == ST_DONE);
      end
   end

   // Input-side beat and candidate position counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_r <= '0;
         in_x_r     <= '0;
         in_y_r     <= '0;
      end else if (init) begin
         beat_cnt_r <= '0;
         in_x_r     <= '0;
         in_y_r     <= '0;
      end else if (accept_s) begin
         if (beat_last_s) begin
            beat_cnt_r <= '0;
            if (in_x_r == POS_LAST) begin
               in_x_r <= '0;
               in_y_r <= in_y_r + POS_W'(1);
            end else begin
               in_x_r <= in_x_r + POS_W'(1);
            end
         end else begin
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
         end
      end
   end

   // Stage 1: per-lane absolute differences with candidate framing flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_r   <= 1'b0;
         s1_first_r <= 1'b0;
         s1_last_r  <= 1'b0;
         for (int l = 0; l < LANES; l++) s1_diff_r[l] <= '0;
      end else if (init) begin
         s1_vld_r   <= 1'b0;
         s1_first_r <= 1'b0;
         s1_last_r  <= 1'b0;
         for (int l = 0; l < LANES; l++) s1_diff_r[l] <= '0;
      end else begin
         s1_vld_r   <= accept_s;
         s1_first_r <= accept_s && (beat_cnt_r == '0);
         s1_last_r  <= accept_s && beat_last_s;
         if (accept_s) begin
            for (int l = 0; l < LANES; l++)
               s1_diff_r[l] <= abs_diff(cur_data[l*WORD_WIDTH +: WORD_WIDTH],
                                        ref_data[l*WORD_WIDTH +: WORD_WIDTH]);
         end
      end
   end

   always_comb begin
      lane_sum_s = '0;
      for (int l = 0; l < LANES; l++) lane_sum_s = lane_sum_s + SAD_W'(s1_diff_r[l]);
   end

   // Stage 2: candidate accumulator, restarted by the first beat of each candidate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r      <= '0;
         acc_done_r <= 1'b0;
      end else if (init) begin
         acc_r      <= '0;
         acc_done_r <= 1'b0;
      end else begin
         acc_done_r <= s1_vld_r & s1_last_r;
         if (s1_vld_r) begin
            if (s1_first_r) acc_r <= lane_sum_s;
            else            acc_r <= acc_r + lane_sum_s;
         end
      end
   end

   // Compare stage: first candidate loads, later ones win only when strictly smaller
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_x_r    <= '0;
         cmp_y_r    <= '0;
         cmp_last_r <= 1'b0;
         min_sad    <= '0;
         mv_x       <= '0;
         mv_y       <= '0;
      end else if (init) begin
         cmp_x_r    <= '0;
         cmp_y_r    <= '0;
         cmp_last_r <= 1'b0;
      end else begin
         cmp_last_r <= acc_done_r && (cmp_x_r == POS_LAST) && (cmp_y_r == POS_LAST);
         if (acc_done_r) begin
            if (cmp_first_s || (acc_r < min_sad)) begin
               min_sad <= acc_r;
               mv_x    <= MV_W'(cmp_x_r) - RANGE_V;
               mv_y    <= MV_W'(cmp_y_r) - RANGE_V;
            end
            if (cmp_x_r == POS_LAST) begin
               cmp_x_r <= '0;
               cmp_y_r <= cmp_y_r + POS_W'(1);
            end else begin
               cmp_x_r <= cmp_x_r + POS_W'(1);
            end
         end
      end
   end

`ifdef ME_CAND_SAD_EN
   // Per-candidate SAD tap, aligned with the compare cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_valid <= 1'b0;
         cand_sad   <= '0;
      end else if (init) begin
         cand_valid <= 1'b0;
      end else begin
         cand_valid <= acc_done_r;
         if (acc_done_r) cand_sad <= acc_r;
      end
   end
`endif

endmodule

// File: tb/tb_me_sad_search.sv
// Randomised bench for me_sad_search (BLOCK_N=4, LANES=4, RANGE=1): a beat-level
// model recomputes each candidate SAD and the raster-first minimum from the accepted beats.
module tb_me_sad_search;
   localparam int WW = 8;
   localparam int LN = 4;
   localparam int BN = 4;
   localparam int RG = 1;
   localparam int SW = WW + $clog2(BN * BN);
   localparam int MW = $clog2(RG + 1) + 1;
   localparam int NB = BN * BN / LN;
   localparam int SP = 2 * RG + 1;
   localparam int NC = SP * SP;
   localparam int NT = NB * NC;
   localparam int M_UNIQ = 0, M_TIE = 1, M_SAT = 2, M_RAND = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              init = 1'b0;
   logic              in_valid = 1'b0;
   logic [LN*WW-1:0]  cur_data = '0;
   logic [LN*WW-1:0]  ref_data = '0;
   logic              in_ready, busy, done;
   logic [SW-1:0]     min_sad;
   logic signed [MW-1:0] mv_x, mv_y;
`ifdef ME_CAND_SAD_EN
   logic              cand_valid;
   logic [SW-1:0]     cand_sad;
   bit                lit_cand = 1'b0;
   bit                c_hit;
   int                c_sad, c_idx;
`endif

   me_sad_search #(.WORD_WIDTH(WW), .LANES(LN), .BLOCK_N(BN), .RANGE(RG)) dut (
      .clk(clk), .rst_n(rst_n), .init(init), .in_valid(in_valid), .in_ready(in_ready),
      .cur_data(cur_data), .ref_data(ref_data), .busy(busy), .done(done),
      .min_sad(min_sad), .mv_x(mv_x), .mv_y(mv_y)
`ifdef ME_CAND_SAD_EN
      , .cand_valid(cand_valid), .cand_sad(cand_sad)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int cyc = 0, acc_cnt = 0, exp_done_cyc = -1, done_cnt = 0, to_err = 0;
   int exp_min = 0, exp_mx = 0, exp_my = 0;
   int cand_cyc [NC];
   int cand_m [NC];
   logic [LN*WW-1:0] beat_c [NT];
   logic [LN*WW-1:0] beat_r [NT];
   int m_idx, m_sum, m_a, m_r, m_best;
   bit lit_en = 1'b0, post_chk = 1'b0;
   int lit_min = 0, lit_mx = 0, lit_my = 0;
   logic [WW-1:0] cur_pix [BN*BN];
   logic [WW-1:0] ref_pix [NC][BN*BN];

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: record accepted beats, score each candidate, pick the raster-first minimum
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n || init) begin
         acc_cnt = 0;
         exp_done_cyc = -1;
         for (int i = 0; i < NC; i++) cand_cyc[i] = -1;
      end else if (in_valid && in_ready && acc_cnt < NT) begin
         beat_c[acc_cnt] = cur_data;
         beat_r[acc_cnt] = ref_data;
         if (acc_cnt % NB == NB - 1) begin
            m_idx = acc_cnt / NB;
            m_sum = 0;
            for (int b = 0; b < NB; b++)
               for (int l = 0; l < LN; l++) begin
                  m_a = int'(beat_c[m_idx*NB+b][l*WW +: WW]);
                  m_r = int'(beat_r[m_idx*NB+b][l*WW +: WW]);
                  m_sum += (m_a > m_r) ? (m_a - m_r) : (m_r - m_a);
               end
            cand_m[m_idx] = m_sum;
            cand_cyc[m_idx] = cyc + 2;
            if (m_idx == NC - 1) begin
               exp_min = cand_m[0];
               m_best = 0;
               for (int i = 1; i < NC; i++)
                  if (cand_m[i] < exp_min) begin
                     exp_min = cand_m[i];
                     m_best = i;
                  end
               exp_mx = (m_best % SP) - RG;
               exp_my = (m_best / SP) - RG;
               exp_done_cyc = cyc + 3;
            end
         end
         acc_cnt++;
      end
   end

   // Single compare process, sampling on the falling edge
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready", longint'(in_ready), 0);
         chk("rst_busy", longint'(busy), 0);
         chk("rst_done", longint'(done), 0);
         chk("rst_min_sad", longint'(min_sad), 0);
         chk("rst_mv_x", longint'($signed(mv_x)), 0);
         chk("rst_mv_y", longint'($signed(mv_y)), 0);
`ifdef ME_CAND_SAD_EN
         chk("rst_cand_valid", longint'(cand_valid), 0);
         chk("rst_cand_sad", longint'(cand_sad), 0);
`endif
      end else begin
         if (cyc == exp_done_cyc - 1) chk("busy_before_done", longint'(busy), 1);
         if (cyc == exp_done_cyc) begin
            chk("done", longint'(done), 1);
            chk("busy_at_done", longint'(busy), 0);
            chk("in_ready_at_done", longint'(in_ready), 0);
            chk("min_sad", longint'(min_sad), exp_min);
            chk("mv_x", longint'($signed(mv_x)), exp_mx);
            chk("mv_y", longint'($signed(mv_y)), exp_my);
            if (lit_en) begin
               chk("pin_model_min", exp_min, lit_min);
               chk("pin_min_sad", longint'(min_sad), lit_min);
               chk("pin_mv_x", longint'($signed(mv_x)), lit_mx);
               chk("pin_mv_y", longint'($signed(mv_y)), lit_my);
            end
            done_cnt++;
         end else begin
            chk("no_stray_done", longint'(done), 0);
         end
`ifdef ME_CAND_SAD_EN
         c_hit = 1'b0;
         c_sad = 0;
         c_idx = 0;
         for (int i = 0; i < NC; i++)
            if (cand_cyc[i] == cyc) begin
               c_hit = 1'b1;
               c_sad = cand_m[i];
               c_idx = i;
            end
         chk("cand_valid", longint'(cand_valid), longint'(c_hit));
         if (c_hit) begin
            chk("cand_sad", longint'(cand_sad), c_sad);
            if (lit_cand) chk("pin_cand_sad", longint'(cand_sad), (c_idx == 5) ? 0 : 16);
         end
`endif
         if (post_chk) begin
            chk("done_count", done_cnt, 1);
            chk("handshake_timeouts", to_err, 0);
            done_cnt = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic gen(input int mode);
      for (int p = 0; p < BN*BN; p++) begin
         case (mode)
            M_SAT:   cur_pix[p] = 8'hFF;
            M_RAND:  cur_pix[p] = 8'($urandom_range(0, 3));
            default: cur_pix[p] = 8'($urandom_range(1, 254));
         endcase
      end
      for (int c = 0; c < NC; c++)
         for (int p = 0; p < BN*BN; p++) begin
            case (mode)
               M_UNIQ:  ref_pix[c][p] = (c == 5) ? cur_pix[p] :
                                        (($urandom & 1) != 0) ? cur_pix[p] + 8'd1 : cur_pix[p] - 8'd1;
               M_TIE:   ref_pix[c][p] = (($urandom & 1) != 0) ? cur_pix[p] + 8'd1 : cur_pix[p] - 8'd1;
               M_SAT:   ref_pix[c][p] = 8'h00;
               default: ref_pix[c][p] = 8'($urandom_range(0, 3));
            endcase
         end
   endtask

   task automatic start();
      init = 1'b1;
      step();
      init = 1'b0;
   endtask

   // gap: 0 none, 1 alternate cycles, 2 random 0..2 idle cycles
   task automatic stream(input int nbeats, input int gap);
      int guard;
      for (int k = 0; k < nbeats; k++) begin
         for (int l = 0; l < LN; l++) begin
            cur_data[l*WW +: WW] = cur_pix[(k % NB)*LN + l];
            ref_data[l*WW +: WW] = ref_pix[k / NB][(k % NB)*LN + l];
         end
         in_valid = 1'b1;
         guard = 0;
         while (!in_ready && guard < 20) begin
            step();
            guard++;
         end
         if (guard >= 20) to_err++;
         step();
         in_valid = 1'b0;
         if (gap == 1) step();
         else if (gap == 2) repeat ($urandom_range(0, 2)) step();
      end
   endtask

   task automatic finish_search();
      repeat (8) step();
      post_chk = 1'b1;
      step();
      post_chk = 1'b0;
   endtask

   task automatic set_lit(input bit en, input int m, input int x, input int y);
      lit_en = en;
      lit_min = m;
      lit_mx = x;
      lit_my = y;
   endtask

   task automatic search(input int mode, input int gap);
      gen(mode);
`ifdef ME_CAND_SAD_EN
      lit_cand = (mode == M_UNIQ);
`endif
      start();
      stream(NT, gap);
      finish_search();
   endtask

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      step();

      set_lit(1'b1, 0, 1, 0);
      search(M_UNIQ, 0);
      set_lit(1'b1, 16, -1, -1);
      search(M_TIE, 0);
      set_lit(1'b1, 4080, -1, -1);
      search(M_SAT, 0);
      set_lit(1'b1, 0, 1, 0);
      search(M_UNIQ, 1);

      // Abort after 10 beats; the beat presented alongside init must be dropped
      gen(M_UNIQ);
      start();
      stream(10, 0);
      cur_data = '1;
      ref_data = '0;
      in_valid = 1'b1;
      init = 1'b1;
      step();
      init = 1'b0;
      in_valid = 1'b0;
      stream(NT, 0);
      finish_search();

      // Reset mid-search, then a clean unique-match search
      gen(M_UNIQ);
      start();
      stream(20, 0);
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      start();
      stream(NT, 0);
      finish_search();

      set_lit(1'b0, 0, 0, 0);
      for (int t = 0; t < 6; t++) search(M_RAND, (t % 2 == 0) ? 0 : 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
